pipe_ser: RTL and testbench

Parallel-to-serial transmitter for the `pipe_pal` parallel word interface. It accepts `W_DATA`-wide words on a valid/ready handshake and shifts each word out MSB-first on a single data line, with a frame strobe marking every data bit. An optional idle gap follows each frame. It sits at the transmit end of the serial link, the opposite direction from the parallel capture path.

---
 rtl/pipe_ser.sv | 83 ++++++++
 tb/tb_pipe_ser.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ser.sv
// pipe_ser: parallel-to-serial transmitter, MSB first, frame strobe per data bit, optional idle gap.
// Latency: first bit 1 cycle after handshake; backpressure via o_ready (IDLE, or last bit when GAP==0).
module pipe_ser #(
  parameter int W_DATA = 32,
  parameter int GAP    = 1
) (
  input  logic              i_clk,
  input  logic              resetn,
  input  logic [W_DATA-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_sdata,
  output logic              o_sframe,
  output logic              o_busy
);

  localparam int W_CNT = $clog2(W_DATA);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [W_DATA-1:0] shreg;
  logic [W_CNT-1:0]  bit_cnt;
  logic [7:0]        gap_cnt;
  logic              last_bit;
  logic              hs;

  assign last_bit = (state == ST_SHIFT) && (bit_cnt == '0);
  assign o_ready  = (state == ST_IDLE) || (last_bit && (GAP == 0));
  assign hs       = i_valid && o_ready;

  // The shift register drains to zero by the last bit, so its MSB is already 0 outside a frame.
  assign o_sdata  = shreg[W_DATA-1];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (hs) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_bit) begin
          if (GAP > 0)  state_nxt = ST_GAP;
          else if (!hs) state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == 8'd0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= 8'd0;
      o_sframe <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_nxt;
      o_sframe <= (state_nxt == ST_SHIFT);
      o_busy   <= (state_nxt != ST_IDLE);

      if (hs) begin
        shreg   <= i_data;
        bit_cnt <= W_CNT'(W_DATA - 1);
      end else if (state == ST_SHIFT) begin
        shreg <= {shreg[W_DATA-2:0], 1'b0};
        if (!last_bit) bit_cnt <= bit_cnt - 1'b1;
      end

      if (last_bit && (GAP > 0)) gap_cnt <= 8'(GAP - 1);
      else if (state == ST_GAP)  gap_cnt <= gap_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ser.sv
// Bench for pipe_ser: three instances (W8/GAP2, W8/GAP0, W32/GAP1); serial bits checked against per-instance queues.
module tb_pipe_ser;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic resetn;

  logic [7:0]  a_data;  logic a_valid, a_ready, a_sdata, a_sframe, a_busy;
  logic [7:0]  b_data;  logic b_valid, b_ready, b_sdata, b_sframe, b_busy;
  logic [31:0] c_data;  logic c_valid, c_ready, c_sdata, c_sframe, c_busy;

  pipe_ser #(.W_DATA(8), .GAP(2)) u_a (
    .i_clk(i_clk), .resetn(resetn), .i_data(a_data), .i_valid(a_valid),
    .o_ready(a_ready), .o_sdata(a_sdata), .o_sframe(a_sframe), .o_busy(a_busy));
  pipe_ser #(.W_DATA(8), .GAP(0)) u_b (
    .i_clk(i_clk), .resetn(resetn), .i_data(b_data), .i_valid(b_valid),
    .o_ready(b_ready), .o_sdata(b_sdata), .o_sframe(b_sframe), .o_busy(b_busy));
  pipe_ser #(.W_DATA(32), .GAP(1)) u_c (
    .i_clk(i_clk), .resetn(resetn), .i_data(c_data), .i_valid(c_valid),
    .o_ready(c_ready), .o_sdata(c_sdata), .o_sframe(c_sframe), .o_busy(c_busy));

  bit qa[$];
  bit qb[$];
  bit qc[$];
  bit ea, eb, ec;
  int n_cmp = 0;
  int n_bad = 0;

  // Serial monitors: every framed bit must match the next queued bit; unframed data must be 0.
  always @(negedge i_clk) begin
    if (a_sframe === 1'b1) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_bad++; $display("FAIL a_bit unexpected frame bit actual=%b required=none", a_sdata);
      end else begin
        ea = qa.pop_front();
        if (a_sdata !== ea) begin n_bad++; $display("FAIL a_bit actual=%b required=%b", a_sdata, ea); end
      end
    end else if (a_sdata !== 1'b0) begin
      n_cmp++; n_bad++; $display("FAIL a_idle_sdata actual=%b required=0", a_sdata);
    end
  end

  always @(negedge i_clk) begin
    if (b_sframe === 1'b1) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_bad++; $display("FAIL b_bit unexpected frame bit actual=%b required=none", b_sdata);
      end else begin
        eb = qb.pop_front();
        if (b_sdata !== eb) begin n_bad++; $display("FAIL b_bit actual=%b required=%b", b_sdata, eb); end
      end
    end else if (b_sdata !== 1'b0) begin
      n_cmp++; n_bad++; $display("FAIL b_idle_sdata actual=%b required=0", b_sdata);
    end
  end

  always @(negedge i_clk) begin
    if (c_sframe === 1'b1) begin
      n_cmp++;
      if (qc.size() == 0) begin
        n_bad++; $display("FAIL c_bit unexpected frame bit actual=%b required=none", c_sdata);
      end else begin
        ec = qc.pop_front();
        if (c_sdata !== ec) begin n_bad++; $display("FAIL c_bit actual=%b required=%b", c_sdata, ec); end
      end
    end else if (c_sdata !== 1'b0) begin
      n_cmp++; n_bad++; $display("FAIL c_idle_sdata actual=%b required=0", c_sdata);
    end
  end

  // Present a word on instance a and wait (bounded) for the handshake; returns #1 after that edge.
  task automatic send_a(input logic [7:0] d);
    bit ok = 0;
    a_data = d; a_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge i_clk);
      if (a_ready) begin
        for (int k = 7; k >= 0; k--) qa.push_back(d[k]);
        ok = 1;
      end
      @(posedge i_clk); #1;
    end
    a_valid = 1'b0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL a_handshake timeout actual=no_ready required=ready"); end
  endtask

  task automatic send_c(input logic [31:0] d);
    bit ok = 0;
    c_data = d; c_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge i_clk);
      if (c_ready) begin
        for (int k = 31; k >= 0; k--) qc.push_back(d[k]);
        ok = 1;
      end
      @(posedge i_clk); #1;
    end
    c_valid = 1'b0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL c_handshake timeout actual=no_ready required=ready"); end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      a_data = 8'($urandom); b_data = 8'($urandom); c_data = $urandom;
      if (j == 3) begin
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        resetn = 1'b1;
      end
      @(negedge i_clk);
      n_cmp++;
      if ({a_sdata, a_sframe, a_busy, a_ready} !== 4'b0001) begin
        n_bad++; $display("FAIL reset_a {sdata,sframe,busy,ready} actual=%b required=0001", {a_sdata, a_sframe, a_busy, a_ready});
      end
      n_cmp++;
      if ({b_sdata, b_sframe, b_busy, b_ready} !== 4'b0001) begin
        n_bad++; $display("FAIL reset_b {sdata,sframe,busy,ready} actual=%b required=0001", {b_sdata, b_sframe, b_busy, b_ready});
      end
      n_cmp++;
      if ({c_sdata, c_sframe, c_busy, c_ready} !== 4'b0001) begin
        n_bad++; $display("FAIL reset_c {sdata,sframe,busy,ready} actual=%b required=0001", {c_sdata, c_sframe, c_busy, c_ready});
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_gap2();
    send_a(8'hA5);
    for (int j = 0; j < 11; j++) begin
      @(negedge i_clk);
      n_cmp++;
      if (a_sframe !== (j < 8)) begin n_bad++; $display("FAIL gap2_sframe cyc=%0d actual=%b required=%b", j, a_sframe, (j < 8)); end
      n_cmp++;
      if (a_busy !== (j < 10)) begin n_bad++; $display("FAIL gap2_busy cyc=%0d actual=%b required=%b", j, a_busy, (j < 10)); end
      n_cmp++;
      if (a_ready !== (j == 10)) begin n_bad++; $display("FAIL gap2_ready cyc=%0d actual=%b required=%b", j, a_ready, (j == 10)); end
    end
    n_cmp++;
    if (qa.size() != 0) begin n_bad++; $display("FAIL gap2_drain bits_left actual=%0d required=0", qa.size()); end
    @(posedge i_clk); #1;
  endtask

  task automatic test_back_to_back();
    b_valid = 1'b1; b_data = 8'hA5;
    @(negedge i_clk);
    n_cmp++;
    if (b_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_ready actual=%b required=1", b_ready); end
    if (b_ready) for (int k = 7; k >= 0; k--) qb.push_back(b_data[k]);
    @(posedge i_clk); #1;
    b_data = 8'h3C;
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < 8; j++) begin
        @(negedge i_clk);
        n_cmp++;
        if (b_sframe !== 1'b1) begin n_bad++; $display("FAIL b2b_sframe word=%0d cyc=%0d actual=%b required=1", w, j, b_sframe); end
        n_cmp++;
        if (b_ready !== (j == 7)) begin n_bad++; $display("FAIL b2b_ready word=%0d cyc=%0d actual=%b required=%b", w, j, b_ready, (j == 7)); end
        if (w == 0 && j == 7 && b_ready) for (int k = 7; k >= 0; k--) qb.push_back(b_data[k]);
        @(posedge i_clk); #1;
      end
      b_valid = 1'b0;
    end
    @(negedge i_clk);
    n_cmp++;
    if ({b_sframe, b_busy, b_ready} !== 3'b001) begin
      n_bad++; $display("FAIL b2b_end {sframe,busy,ready} actual=%b required=001", {b_sframe, b_busy, b_ready});
    end
    n_cmp++;
    if (qb.size() != 0) begin n_bad++; $display("FAIL b2b_drain bits_left actual=%0d required=0", qb.size()); end
    @(posedge i_clk); #1;
  endtask

  task automatic test_backpressure();
    logic [7:0] pat [3];
    pat[0] = 8'h00; pat[1] = 8'h55; pat[2] = 8'hAA;
    send_a(8'hFF);
    a_valid = 1'b1;
    for (int j = 0; j < 11; j++) begin
      a_data = pat[j % 3];
      @(negedge i_clk);
      n_cmp++;
      if (a_ready !== (j == 10)) begin n_bad++; $display("FAIL bp_ready cyc=%0d actual=%b required=%b", j, a_ready, (j == 10)); end
      if (j == 10 && a_ready) for (int k = 7; k >= 0; k--) qa.push_back(a_data[k]);
      @(posedge i_clk); #1;
    end
    a_valid = 1'b0;
    repeat (11) @(negedge i_clk);
    #1;
    n_cmp++;
    if (qa.size() != 0) begin n_bad++; $display("FAIL bp_drain bits_left actual=%0d required=0", qa.size()); end
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset_mid();
    send_a(8'hA5);
    repeat (3) @(negedge i_clk);
    #1;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({a_sdata, a_sframe, a_busy} !== 3'b000) begin
      n_bad++; $display("FAIL midreset_async {sdata,sframe,busy} actual=%b required=000", {a_sdata, a_sframe, a_busy});
    end
    qa.delete();
    @(posedge i_clk); #1;
    resetn = 1'b1;
    send_a(8'h81);
    for (int j = 0; j < 8; j++) begin
      @(negedge i_clk);
      n_cmp++;
      if (a_sframe !== 1'b1) begin n_bad++; $display("FAIL midreset_frame cyc=%0d actual=%b required=1", j, a_sframe); end
    end
    repeat (3) @(negedge i_clk);
    #1;
    n_cmp++;
    if (qa.size() != 0) begin n_bad++; $display("FAIL midreset_drain bits_left actual=%0d required=0", qa.size()); end
    @(posedge i_clk); #1;
  endtask

  task automatic test_w32();
    send_c(32'h8000_0001);
    for (int j = 0; j < 34; j++) begin
      @(negedge i_clk);
      n_cmp++;
      if (c_sframe !== (j < 32)) begin n_bad++; $display("FAIL w32_sframe cyc=%0d actual=%b required=%b", j, c_sframe, (j < 32)); end
      n_cmp++;
      if (c_busy !== (j < 33)) begin n_bad++; $display("FAIL w32_busy cyc=%0d actual=%b required=%b", j, c_busy, (j < 33)); end
      n_cmp++;
      if (c_ready !== (j == 33)) begin n_bad++; $display("FAIL w32_ready cyc=%0d actual=%b required=%b", j, c_ready, (j == 33)); end
    end
    n_cmp++;
    if (qc.size() != 0) begin n_bad++; $display("FAIL w32_drain bits_left actual=%0d required=0", qc.size()); end
    @(posedge i_clk); #1;
  endtask

  initial begin
    resetn = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    a_data = '0; b_data = '0; c_data = '0;
    test_reset();
    test_gap2();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_w32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
